// File: rtl/fft_reorder_buffer_if.sv
// fft_reorder_buffer_if
//
// Sample bus around the bit-reversal reorder buffer.
//   di_en / di_re / di_im : FFT samples in bit-reversed bin order (N-cycle bursts)
//   do_en / do_re / do_im : samples replayed in natural bin order
//   do_idx                : bin index of the current output sample
//   do_last               : high with bin N-1 of each output frame
// Modports:
//   master : upstream/testbench side (drives di_*, observes do_*)
//   slave  : the reorder buffer itself (consumes di_*, drives do_*)
interface fft_reorder_buffer_if #(
    parameter int N     = 64,
    parameter int WIDTH = 16
);
    localparam int LOG_N = $clog2(N);

    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;

    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
    logic [LOG_N-1:0] do_idx;
    logic             do_last;

    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im, do_idx, do_last
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im, do_idx, do_last
    );
endinterface

// File: rtl/fft_reorder_buffer.sv
// fft_reorder_buffer
//
// Captures each N-point FFT frame (delivered in bit-reversed bin order) into
// one half of a ping-pong memory and replays it in natural bin order. Bin 0
// of a frame leaves two clock edges after the frame's last input sample;
// back-to-back input frames produce back-to-back output frames.
//
// Ports:
//   clock : master clock, rising edge
//   reset : synchronous, active-high; empties both banks, clears outputs
//   bus   : fft_reorder_buffer_if.slave (di_* in, do_* out)
module fft_reorder_buffer #(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    fft_reorder_buffer_if.slave   bus
);
    localparam int               LOG_N   = $clog2(N);
    localparam logic [LOG_N-1:0] CNT_MAX = LOG_N'(N - 1);

    typedef enum logic {
        S_IDLE,
        S_READ
    } rd_state_t;

    // ------------------------------------------------------------------
    // Writer
    // ------------------------------------------------------------------
    logic [LOG_N-1:0] wr_cnt_q;
    logic             wr_bank_q;
    logic [LOG_N-1:0] wr_addr;
    logic             wr_done;

    // Input position p carries bin bitrev(p), so storing at bitrev(p)
    // places every sample at its natural bin address.
    for (genvar gi = 0; gi < LOG_N; gi++) begin : g_bitrev
        assign wr_addr[gi] = wr_cnt_q[LOG_N-1-gi];
    end

    assign wr_done = bus.di_en && (wr_cnt_q == CNT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
        end else if (bus.di_en) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;   // wraps to 0 on frame completion
            if (wr_cnt_q == CNT_MAX) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end else begin
            // A gap inside a frame throws the partial frame away.
            wr_cnt_q <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong storage: bank select is the address MSB.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] mem_q [0:2*N-1];
    logic [2*WIDTH-1:0] rd_data_q;
    logic               rd_bank_q;
    logic [LOG_N-1:0]   rd_cnt_q;
    rd_state_t          state_q;
    logic               rd_en;

    assign rd_en = (state_q == S_READ);

    always_ff @(posedge clock) begin
        if (bus.di_en && !reset) begin
            mem_q[{wr_bank_q, wr_addr}] <= {bus.di_re, bus.di_im};
        end
    end

    // Registered read; no reset so it maps onto the block RAM output port.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data_q <= mem_q[{rd_bank_q, rd_cnt_q}];
        end
    end

    // ------------------------------------------------------------------
    // Bank-full flags
    // ------------------------------------------------------------------
    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       rd_done;

    assign rd_done = rd_en && (rd_cnt_q == CNT_MAX);

    always_comb begin
        full_d = full_q;
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        // Applied second so a set beats a clear on the same bit.
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    // ------------------------------------------------------------------
    // Reader FSM with registered output qualifiers
    // ------------------------------------------------------------------
    logic             do_en_q;
    logic [LOG_N-1:0] do_idx_q;
    logic             do_last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            do_en_q   <= 1'b0;
            do_idx_q  <= '0;
            do_last_q <= 1'b0;
        end else begin
            do_en_q   <= 1'b0;
            do_idx_q  <= '0;
            do_last_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|full_q) begin
                        // If both were full, the bank the writer returns to
                        // next is the older one.
                        rd_bank_q <= full_q[wr_bank_q] ? wr_bank_q : ~wr_bank_q;
                        rd_cnt_q  <= '0;
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    do_en_q   <= 1'b1;
                    do_idx_q  <= rd_cnt_q;
                    do_last_q <= (rd_cnt_q == CNT_MAX);
                    if (rd_cnt_q == CNT_MAX) begin
                        // Only a flag already registered keeps the reader
                        // going; a frame finishing on this very edge is
                        // picked up through IDLE so that every frame sees
                        // the same two-edge latency and input gaps survive.
                        if (full_q[~rd_bank_q]) begin
                            rd_bank_q <= ~rd_bank_q;
                            rd_cnt_q  <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.do_en   = do_en_q;
    assign bus.do_idx  = do_idx_q;
    assign bus.do_last = do_last_q;
    assign bus.do_re   = do_en_q ? rd_data_q[2*WIDTH-1:WIDTH] : '0;
    assign bus.do_im   = do_en_q ? rd_data_q[WIDTH-1:0]       : '0;
endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Bench for fft_reorder_buffer (N=64, WIDTH=16). The reference model keeps
// each input frame as it arrives; when a frame completes on clock cycle E it
// schedules bin j (value taken from input position bitrev(j)) for cycle
// E+2+j. Every cycle the full output bundle is compared to the schedule
// (all-zero when nothing is scheduled).
module tb_fft_reorder_buffer;
    localparam int N     = 64;
    localparam int WIDTH = 16;
    localparam int LOG_N = 6;

    logic clock;
    logic reset;

    fft_reorder_buffer_if #(.N(N), .WIDTH(WIDTH)) bus ();

    fft_reorder_buffer #(.N(N), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model state
    int          cyc = 0;
    int          in_cnt = 0;
    logic [31:0] in_buf [N];
    logic [39:0] exp_map [int];
    int          last_in_cyc = 0;

    // Observation bookkeeping
    int          run = 0;
    int          runs [$];
    int          wraps = 0;
    int          lasts = 0;
    int          first_out_cyc = -1;
    logic        prev_en = 1'b0;
    logic [5:0]  prev_idx = '0;
    logic [15:0] cap_re [N];
    logic [15:0] cap_im [N];

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < LOG_N; b++) begin
            if (v & (1 << b)) r |= 1 << (LOG_N - 1 - b);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic phase_start();
        runs.delete();
        run = 0;
        wraps = 0;
        lasts = 0;
        first_out_cyc = -1;
    endtask

    task automatic tick(input logic rst, input logic en, input logic [15:0] re, input logic [15:0] im);
        logic [39:0] exp_v;
        logic [39:0] got_v;
        reset     = rst;
        bus.di_en = en;
        bus.di_re = re;
        bus.di_im = im;
        @(posedge clock);
        cyc++;
        if (rst) begin
            in_cnt = 0;
            exp_map.delete();
        end else if (en) begin
            in_buf[in_cnt] = {re, im};
            in_cnt++;
            if (in_cnt == N) begin
                for (int j = 0; j < N; j++) begin
                    exp_map[cyc + 2 + j] = {1'b1, 6'(j), (j == N - 1), in_buf[bitrev(j)]};
                end
                in_cnt = 0;
                last_in_cyc = cyc;
            end
        end else begin
            in_cnt = 0;
        end
        #1;
        exp_v = exp_map.exists(cyc) ? exp_map[cyc] : 40'd0;
        got_v = {bus.do_en, bus.do_idx, bus.do_last, bus.do_re, bus.do_im};
        check("out_bundle", {24'd0, got_v}, {24'd0, exp_v});

        if (bus.do_en === 1'b1) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            run++;
            cap_re[bus.do_idx] = bus.do_re;
            cap_im[bus.do_idx] = bus.do_im;
            if (prev_en && prev_idx == 6'd63 && bus.do_idx == 6'd0) wraps++;
        end else if (run > 0) begin
            runs.push_back(run);
            run = 0;
        end
        if (bus.do_last === 1'b1) lasts++;
        prev_en  = (bus.do_en === 1'b1);
        prev_idx = bus.do_idx;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic frame(input int off);
        for (int k = 0; k < N; k++) tick(1'b0, 1'b1, 16'(k + off), 16'(-(k + off)));
    endtask

    initial begin
        reset     = 1'b1;
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;

        // Reset state: outputs all zero while reset is held
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 16'h1234, 16'h5678);
        check("reset_do_en", {63'd0, bus.do_en}, 64'd0);
        idle(2);

        // Index frame
        phase_start();
        frame(0);
        idle(70);
        check("idx_latency", 64'(first_out_cyc - last_in_cyc), 64'd2);
        check("idx_bin1_re", {48'd0, cap_re[1]}, 64'd32);
        check("idx_bin2_re", {48'd0, cap_re[2]}, 64'd16);
        check("idx_bin63_re", {48'd0, cap_re[63]}, 64'd63);
        check("idx_bin1_im", {48'd0, cap_im[1]}, {48'd0, 16'hFFE0});
        check("idx_last_count", 64'(lasts), 64'd1);
        check("idx_run_len", 64'(runs.size() == 1 ? runs[0] : -1), 64'd64);

        // Three back-to-back frames
        phase_start();
        frame(0);
        frame(100);
        frame(200);
        idle(70);
        check("b2b_run_count", 64'(runs.size()), 64'd1);
        check("b2b_run_len", 64'(runs.size() > 0 ? runs[0] : -1), 64'd192);
        check("b2b_wraps", 64'(wraps), 64'd2);
        check("b2b_bin1_re", {48'd0, cap_re[1]}, 64'd232);

        // Partial frame abort followed by a full frame
        phase_start();
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 16'(500 + k), 16'(500 + k));
        idle(5);
        frame(1000);
        idle(70);
        check("abort_run_count", 64'(runs.size()), 64'd1);
        check("abort_run_len", 64'(runs.size() > 0 ? runs[0] : -1), 64'd64);
        check("abort_bin0_re", {48'd0, cap_re[0]}, 64'd1000);
        check("abort_bin1_re", {48'd0, cap_re[1]}, 64'd1032);

        // Reset at output bin 30 of frame A while frame B is half written
        phase_start();
        frame(300);
        for (int k = 0; k < 32; k++) tick(1'b0, 1'b1, 16'(600 + k), 16'(600 + k));
        check("rst_pre_idx", {58'd0, bus.do_idx}, 64'd30);
        tick(1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
        check("rst_do_en", {63'd0, bus.do_en}, 64'd0);
        check("rst_do_idx", {58'd0, bus.do_idx}, 64'd0);
        check("rst_do_re", {48'd0, bus.do_re}, 64'd0);
        idle(5);
        phase_start();
        frame(700);
        idle(70);
        check("rst_fresh_runs", 64'(runs.size()), 64'd1);
        check("rst_fresh_bin63", {48'd0, cap_re[63]}, 64'd763);

        // Extreme values
        phase_start();
        for (int k = 0; k < N; k++) begin
            if (k % 2 == 0) tick(1'b0, 1'b1, 16'h7FFF, 16'h8000);
            else            tick(1'b0, 1'b1, 16'h8000, 16'h7FFF);
        end
        idle(70);
        check("ext_bin1_re", {48'd0, cap_re[1]}, 64'h7FFF);
        check("ext_bin32_re", {48'd0, cap_re[32]}, 64'h8000);
        check("ext_bin32_im", {48'd0, cap_im[32]}, 64'h7FFF);

        // Random data, random gaps (gap 0 and 1 forced early)
        for (int f = 0; f < 20; f++) begin
            int gap;
            gap = (f < 2) ? f : int'($urandom_range(0, 50));
            for (int k = 0; k < N; k++) tick(1'b0, 1'b1, 16'($urandom), 16'($urandom));
            idle(gap);
        end
        idle(70);
        check("rand_drained", 64'(exp_map.exists(cyc + 1)), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
